// File: rtl/uart_rx_oversampled_if.sv
// Receive handshake bundle: byte valid/ready plus error pulses.
// UART_RX_PARITY_EN adds the parity_err pulse.
`timescale 1ns/1ps
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    output rx_data, rx_valid,
    output frame_err, overrun,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid,
    input  frame_err, overrun,
    input  parity_err,
    output rx_ready
  );
`else
  modport master (
    output rx_data, rx_valid,
    output frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid,
    input  frame_err, overrun,
    output rx_ready
  );
`endif
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receiver on an OSR x baud tick, mid-bit sampling, valid/ready out.
// UART_RX_PARITY_EN adds an even-parity bit and parity_err pulse.
`timescale 1ns/1ps
module uart_rx_oversampled #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_tick,
  input  logic rxd,
  output logic busy,
  uart_rx_oversampled_if.master rx
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OSR - 1);
  localparam logic [BW-1:0] LBIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [TW-1:0]        r_tick_cnt;
  logic [TW-1:0]        w_tick_nx;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_nx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_done;
  logic                 w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
  logic                 w_par_nx;
  logic                 r_perr;
`endif

  // two-flop synchronizer, idle-high preset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // frame state and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_tick_cnt <= w_tick_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
`ifdef UART_RX_PARITY_EN
      r_par      <= w_par_nx;
`endif
    end
  end

  // next-state: everything advances only on rx_tick
  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = r_tick_cnt;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nx   = r_par;
`endif
    if (rx_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            w_state_nx = S_START;
            w_tick_nx  = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == HALF) begin
            w_tick_nx = '0;
            if (!r_sync2) begin
              w_state_nx = S_DATA;
              w_bit_nx   = '0;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_tick_nx = r_tick_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (r_tick_cnt == LAST) begin
            w_tick_nx  = '0;
            w_shift_nx = {r_sync2,
                          r_shift[DATA_BITS-1:1]};
            w_bit_nx   = r_bit_cnt + BW'(1);
            if (r_bit_cnt == LBIT) begin
`ifdef UART_RX_PARITY_EN
              w_state_nx = S_PARITY;
`else
              w_state_nx = S_STOP;
`endif
            end
          end else begin
            w_tick_nx = r_tick_cnt + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_tick_cnt == LAST) begin
            w_tick_nx  = '0;
            w_par_nx   = r_sync2;
            w_state_nx = S_STOP;
          end else begin
            w_tick_nx = r_tick_cnt + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (r_tick_cnt == LAST) begin
            w_tick_nx = '0;
            if (r_sync2) begin
              w_done     = 1'b1;
              w_state_nx = S_IDLE;
            end else begin
              w_ferr     = 1'b1;
              w_state_nx = S_BREAK;
            end
          end else begin
            w_tick_nx = r_tick_cnt + TW'(1);
          end
        end
        S_BREAK: begin
          if (r_sync2) begin
            w_state_nx = S_IDLE;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  // output holding register, handshake and error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= w_done & (^{r_shift, r_par});
`endif
      if (w_done) begin
        if (!r_valid || rx.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx.rx_data   = r_data;
  assign rx.rx_valid  = r_valid;
  assign rx.frame_err = r_ferr;
  assign rx.overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = r_perr;
`endif
  assign busy = (r_state != S_IDLE);

endmodule
